// File: rtl/alu_flag_latch.sv
// alu_flag_latch: result/flag register stage behind the jrb8 ALU, with jump-condition evaluation.
// Optional flag stack for call/interrupt save/restore is built when `ALU_FLAG_STACK_EN is defined.
module alu_flag_latch #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_alu_result,
    input  logic       i_alu_carry,
    input  logic       i_alu_over,
    input  logic       i_alu_cmp,
    input  logic       i_latch,
    input  logic [2:0] i_cond,
    input  logic       i_cond_req,
    input  logic       i_flag_push,
    input  logic       i_flag_pop,
    output logic [7:0] o_result,
    output logic       o_result_valid,
    output logic [3:0] o_flags,
    output logic       o_carry_fb,
    output logic       o_take,
    output logic       o_take_valid,
    output logic       o_stk_err
);
    // Flag bit order is {O,C,S,Z}
    logic [7:0] r_result;
    logic       r_result_valid;
    logic [3:0] r_flags;
    logic       r_take;
    logic       r_take_valid;

    logic [3:0] w_latch_flags;
    logic [3:0] w_next_flags;
    logic [3:0] w_pop_flags;
    logic       w_pop_ok;
    logic       w_take;

    assign w_latch_flags = {i_alu_over, i_alu_carry, i_alu_result[7], (i_alu_result == 8'h00)};

`ifdef ALU_FLAG_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic [SPW-1:0] r_sp;
    logic [3:0]     r_stack [STACK_DEPTH];
    logic           r_stk_err;
    logic           w_push_ok;
    logic           w_stk_fault;

    // Pop outranks push; an overflowing push or underflowing pop is dropped and reported.
    always_comb begin
        w_pop_ok    = i_flag_pop && (r_sp != {SPW{1'b0}});
        w_push_ok   = i_flag_push && !i_flag_pop && (r_sp != SPW'(STACK_DEPTH));
        w_stk_fault = (i_flag_pop && (r_sp == {SPW{1'b0}})) ||
                      (i_flag_push && !i_flag_pop && (r_sp == SPW'(STACK_DEPTH)));
        w_pop_flags = 4'b0000;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SPW'(i + 1)) begin
                w_pop_flags = r_stack[i];
            end else begin
                w_pop_flags = w_pop_flags;
            end
        end
    end

    // Stack pointer, storage and sticky error; push saves the flags as they were before this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp      <= {SPW{1'b0}};
            r_stk_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= 4'b0000;
            end
        end else begin
            if (w_pop_ok) begin
                r_sp <= r_sp - SPW'(1);
            end else if (w_push_ok) begin
                r_sp <= r_sp + SPW'(1);
            end
            if (w_stk_fault) begin
                r_stk_err <= 1'b1;
            end
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (w_push_ok && (r_sp == SPW'(i))) begin
                    r_stack[i] <= r_flags;
                end
            end
        end
    end

    assign o_stk_err = r_stk_err;
`else
    logic w_unused_stk;

    assign w_pop_ok     = 1'b0;
    assign w_pop_flags  = 4'b0000;
    assign w_unused_stk = ^{i_flag_push, i_flag_pop};
    assign o_stk_err    = 1'b0;
`endif

    // Flags about to be written this edge; also the bypass source for condition evaluation.
    always_comb begin
        if (w_pop_ok) begin
            w_next_flags = w_pop_flags;
        end else if (i_latch) begin
            w_next_flags = w_latch_flags;
        end else begin
            w_next_flags = r_flags;
        end
    end

    // Jump condition decode against the bypassed flags.
    always_comb begin
        case (i_cond)
            3'd0:    w_take = 1'b1;
            3'd1:    w_take = w_next_flags[0];
            3'd2:    w_take = !w_next_flags[0];
            3'd3:    w_take = w_next_flags[2];
            3'd4:    w_take = !w_next_flags[2];
            3'd5:    w_take = w_next_flags[1];
            3'd6:    w_take = w_next_flags[3];
            3'd7:    w_take = w_next_flags[1] ^ w_next_flags[3];
            default: w_take = 1'b0;
        endcase
    end

    // Result, flag and condition-outcome registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result       <= 8'h00;
            r_result_valid <= 1'b0;
            r_flags        <= 4'b0000;
            r_take         <= 1'b0;
            r_take_valid   <= 1'b0;
        end else begin
            r_flags        <= w_next_flags;
            r_result_valid <= i_latch && !i_alu_cmp;
            if (i_latch && !i_alu_cmp) begin
                r_result <= i_alu_result;
            end
            r_take_valid <= i_cond_req;
            if (i_cond_req) begin
                r_take <= w_take;
            end
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_flags        = r_flags;
    assign o_carry_fb     = r_flags[2];
    assign o_take         = r_take;
    assign o_take_valid   = r_take_valid;
endmodule

// File: tb/tb_alu_flag_latch.sv
// Self-checking bench for alu_flag_latch: directed scenarios plus randomized traffic against a
// behavioural model (queue-based flag stack). Stack expectations follow `ALU_FLAG_STACK_EN.
module tb_alu_flag_latch;
`ifdef ALU_FLAG_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_result;
    logic       alu_carry, alu_over, alu_cmp, latch_in;
    logic [2:0] cond;
    logic       cond_req, flag_push, flag_pop;
    logic [7:0] result;
    logic       result_valid;
    logic [3:0] flags;
    logic       carry_fb, take, take_valid, stk_err;

    int n_tests = 0;
    int n_fail  = 0;

    bit [7:0] m_result;
    bit       m_rv, m_take, m_tv, m_err;
    bit [3:0] m_flags;
    bit [3:0] m_stack[$];

    always #5 clk = ~clk;

    alu_flag_latch #(.STACK_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_alu_result(alu_result), .i_alu_carry(alu_carry),
        .i_alu_over(alu_over), .i_alu_cmp(alu_cmp), .i_latch(latch_in), .i_cond(cond),
        .i_cond_req(cond_req), .i_flag_push(flag_push), .i_flag_pop(flag_pop),
        .o_result(result), .o_result_valid(result_valid), .o_flags(flags),
        .o_carry_fb(carry_fb), .o_take(take), .o_take_valid(take_valid), .o_stk_err(stk_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_met(input bit [2:0] c, input bit [3:0] f);
        bit z, s, cy, ov;
        {ov, cy, s, z} = f;
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return cy;
            3'd4:    return !cy;
            3'd5:    return s;
            3'd6:    return ov;
            default: return s != ov;
        endcase
    endfunction

    // Advance the reference model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit [3:0] lf, nf;
        bit       pop_ok, push_ok, push_only;
        int       n;
        if (rst) begin
            m_result = 8'h00; m_rv = 1'b0; m_flags = 4'b0000;
            m_take = 1'b0; m_tv = 1'b0; m_err = 1'b0;
            m_stack.delete();
            return;
        end
        n         = m_stack.size();
        push_only = flag_push && !flag_pop;
        lf        = {alu_over, alu_carry, (alu_result >= 8'd128), (alu_result == 8'd0)};
        pop_ok    = STK_EN && flag_pop && (n > 0);
        push_ok   = STK_EN && push_only && (n < DEPTH);
        if (STK_EN && ((flag_pop && n == 0) || (push_only && n == DEPTH))) m_err = 1'b1;
        if (pop_ok)        nf = m_stack.pop_back();
        else if (latch_in) nf = lf;
        else               nf = m_flags;
        if (push_ok) m_stack.push_back(m_flags);
        m_rv = latch_in && !alu_cmp;
        if (m_rv) m_result = alu_result;
        m_tv = cond_req;
        if (cond_req) m_take = cond_met(cond, nf);
        m_flags = nf;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("result", 32'(result), 32'(m_result));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("flags", 32'(flags), 32'(m_flags));
        check("carry_fb", 32'(carry_fb), 32'(m_flags[2]));
        check("take_valid", 32'(take_valid), 32'(m_tv));
        if (m_tv) check("take", 32'(take), 32'(m_take));
        check("stk_err", 32'(stk_err), 32'(m_err));
    endtask

    task automatic drive(input logic [7:0] r, input logic c, input logic o, input logic cmp,
                         input logic l, input logic [2:0] cd, input logic cr,
                         input logic ps, input logic pp, input logic rs);
        alu_result = r; alu_carry = c; alu_over = o; alu_cmp = cmp; latch_in = l;
        cond = cd; cond_req = cr; flag_push = ps; flag_pop = pp; rst = rs;
        cycle();
    endtask

    initial begin
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_result", 32'(result), 32'h00);
        check("rst_flags", 32'(flags), 32'h0);

        // Zero result with carry
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_flags", 32'(flags), 32'b0101);
        check("t1_valid", 32'(result_valid), 32'h1);
        check("t1_carry_fb", 32'(carry_fb), 32'h1);

        // Compare op updates flags only
        drive(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_result", 32'(result), 32'h3C);
        check("t2_valid", 32'(result_valid), 32'h0);
        check("t2_flags", 32'(flags), 32'b0010);

        // Signed less-than, then same-cycle bypass
        drive(8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_take_lt", 32'(take), 32'h1);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_take_bypass", 32'(take), 32'h1);
        drive(8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_take_bypass_nz", 32'(take), 32'h0);

        // Stack fill, overflow, LIFO drain, underflow
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_FLAG_STACK_EN
        check("t4_overflow", 32'(stk_err), 32'h1);
`endif
        for (int k = 0; k < 5; k++) begin
            drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef ALU_FLAG_STACK_EN
            if (k < 4) check("t4_pop_lifo", 32'(flags), 32'(4'b1000 >> k));
            else       check("t4_pop_empty", 32'(flags), 32'b0001);
`endif
        end

        // Reset right after a pending condition request
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_take_valid", 32'(take_valid), 32'h0);
        check("t5_flags", 32'(flags), 32'h0);
        check("t5_result", 32'(result), 32'h00);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            drive(r, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
